// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: ALIGN -> ADD -> NORM -> ROUND, round-to-nearest-even,
// subnormals flushed to zero, status flags {invalid, overflow, underflow, inexact}.
module fp_addsub_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_op_sub,
    input  logic [EXP_W+MAN_W:0]   i_a,
    input  logic [EXP_W+MAN_W:0]   i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [EXP_W+MAN_W:0]   o_result,
    output logic [3:0]             o_flags
);
    localparam int unsigned W  = EXP_W + MAN_W + 1;
    localparam int unsigned MW = MAN_W + 4;  // hidden, fraction, G, R, S
    localparam int unsigned DW = MAN_W + 5;  // plus carry
    localparam int unsigned EW = EXP_W + 2;  // room for carry and a negative sign
    localparam logic [EW-1:0] ExpMax = EW'((2 ** EXP_W) - 1);
    localparam logic [W-1:0]  QNan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

    state_e          r_state, w_state_nxt;
    logic [W-1:0]    r_a, r_b, r_spec_res, r_result;
    logic [3:0]      r_spec_flg, r_flags;
    logic            r_spec, r_sign, r_zsign, r_sub, r_zero, r_uf, r_done;
    logic [EW-1:0]   r_exp;
    logic [MW-1:0]   r_ml, r_ms, r_nman;
    logic [DW-1:0]   r_sum;

    // ALIGN stage
    logic               w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_spec;
    logic [EXP_W-1:0]   w_ea, w_eb, w_el, w_es, w_diff;
    logic [MAN_W-1:0]   w_fa, w_fb;
    logic [MW-1:0]      w_ma, w_mb, w_ml, w_msm, w_ms_al, w_mask;
    logic [W-1:0]       w_spec_res;
    logic [3:0]         w_spec_flg;

    always_comb begin
        w_sa    = r_a[W-1];
        w_sb    = r_b[W-1];
        w_ea    = r_a[W-2:MAN_W];
        w_eb    = r_b[W-2:MAN_W];
        w_fa    = (w_ea == '0) ? '0 : r_a[MAN_W-1:0];
        w_fb    = (w_eb == '0) ? '0 : r_b[MAN_W-1:0];
        w_a_nan = (&w_ea) & (|w_fa);
        w_b_nan = (&w_eb) & (|w_fb);
        w_a_inf = (&w_ea) & ~(|w_fa);
        w_b_inf = (&w_eb) & ~(|w_fb);
        w_ma    = {(w_ea != '0), w_fa, 3'b000};
        w_mb    = {(w_eb != '0), w_fb, 3'b000};
        w_swap  = {w_eb, w_fb} > {w_ea, w_fa};
        w_el    = w_swap ? w_eb : w_ea;
        w_es    = w_swap ? w_ea : w_eb;
        w_ml    = w_swap ? w_mb : w_ma;
        w_msm   = w_swap ? w_ma : w_mb;
        w_diff  = w_el - w_es;
        w_mask  = ~({MW{1'b1}} << w_diff);
        if (32'(w_diff) >= MAN_W + 3) begin
            w_ms_al = {{(MW-1){1'b0}}, |w_msm};
        end else begin
            w_ms_al = (w_msm >> w_diff) | {{(MW-1){1'b0}}, |(w_msm & w_mask)};
        end
        w_spec     = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
        w_spec_res = r_b;
        w_spec_flg = 4'b0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = QNan;
            w_spec_flg = {(w_a_nan & ~w_fa[MAN_W-1]) | (w_b_nan & ~w_fb[MAN_W-1]), 3'b000};
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_res = QNan;
            w_spec_flg = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_res = r_a;
        end
    end

    // ADD, NORM and ROUND stages
    logic [DW-1:0]    w_sum;
    logic [EW-1:0]    w_lzc, w_nexp, w_rexp;
    logic [MW-1:0]    w_nman;
    logic             w_inc;
    logic [MAN_W+1:0] w_rman;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]     w_res;
    logic [3:0]       w_flg;

    always_comb begin
        w_sum = r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});
        w_lzc = '0;
        for (int i = 0; i < MW; i++) begin
            if (r_sum[i]) w_lzc = EW'(MW - 1 - i);
        end
        if (r_sum[DW-1]) begin
            w_nman = {r_sum[DW-1:2], r_sum[1] | r_sum[0]};
            w_nexp = r_exp + 1'b1;
        end else begin
            w_nman = r_sum[MW-1:0] << w_lzc;
            w_nexp = r_exp - w_lzc;
        end
        w_inc  = r_nman[2] & (r_nman[1] | r_nman[0] | r_nman[3]);
        w_rman = {1'b0, r_nman[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
        w_rexp = r_exp + {{(EW-1){1'b0}}, w_rman[MAN_W+1]};
        w_frac = w_rman[MAN_W+1] ? w_rman[MAN_W:1] : w_rman[MAN_W-1:0];
        if (r_spec) begin
            w_res = r_spec_res;
            w_flg = r_spec_flg;
        end else if (r_zero) begin
            w_res = {r_zsign, {(W-1){1'b0}}};
            w_flg = 4'b0000;
        end else if (r_uf) begin
            w_res = {r_sign, {(W-1){1'b0}}};
            w_flg = 4'b0011;
        end else if (w_rexp >= ExpMax) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end else begin
            w_res = {r_sign, w_rexp[EXP_W-1:0], w_frac};
            w_flg = {3'b000, |r_nman[2:0]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_nxt = StAlign;
            StAlign: w_state_nxt = StAdd;
            StAdd:   w_state_nxt = StNorm;
            StNorm:  w_state_nxt = StRound;
            StRound: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0; r_b <= '0; r_spec_res <= '0; r_spec_flg <= '0; r_spec <= 1'b0;
            r_sign <= 1'b0; r_zsign <= 1'b0; r_sub <= 1'b0; r_exp <= '0;
            r_ml <= '0; r_ms <= '0; r_sum <= '0; r_nman <= '0; r_zero <= 1'b0; r_uf <= 1'b0;
            r_done <= 1'b0; r_result <= '0; r_flags <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: if (i_start) begin
                    r_a <= i_a;
                    r_b <= i_b ^ {i_op_sub, {(W-1){1'b0}}};
                end
                StAlign: begin
                    r_spec     <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_spec_flg <= w_spec_flg;
                    r_sign     <= w_swap ? w_sb : w_sa;
                    r_zsign    <= w_sa & w_sb;
                    r_sub      <= w_sa ^ w_sb;
                    r_exp      <= {2'b00, w_el};
                    r_ml       <= w_ml;
                    r_ms       <= w_ms_al;
                end
                StAdd: r_sum <= w_sum;
                StNorm: begin
                    r_nman <= w_nman;
                    r_exp  <= w_nexp;
                    r_zero <= (r_sum == '0);
                    r_uf   <= w_nexp[EW-1] || (w_nexp == '0);
                end
                StRound: begin
                    r_result <= w_res;
                    r_flags  <= w_flg;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state != StIdle);
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_flags  = r_flags;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single-precision vectors, back-to-back issue, reset abort,
// and a half-precision (EXP_W=5, MAN_W=10) build.
module tb_fp_addsub_seq;
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, op_sub = 1'b0;
    logic [31:0] a = '0, b = '0, result;
    logic        busy, done;
    logic [3:0]  flags;
    logic        h_start = 1'b0, h_op_sub = 1'b0;
    logic [15:0] h_a = '0, h_b = '0, h_result;
    logic        h_busy, h_done;
    logic [3:0]  h_flags;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    localparam int NV = 15;
    logic [31:0] va[NV] = '{32'h3F800000, 32'h3FC00000, 32'h80000000, 32'h3F800000, 32'h3F800000,
                            32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h3F800001,
                            32'h7F800001, 32'h7FC00001, 32'h00800001, 32'h00000001, 32'h3F800000};
    logic [31:0] vb[NV] = '{32'h40000000, 32'h3FC00000, 32'h80000000, 32'h33800000, 32'h33800001,
                            32'h33800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h00800000, 32'h3F800000, 32'h40000000};
    logic        vs[NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] vr[NV] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800001,
                            32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h34000000,
                            32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h3F800000, 32'hBF800000};
    logic [3:0]  vf[NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b1000,
                            4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0000};

    fp_addsub_seq u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_sub(op_sub), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_result(result), .o_flags(flags)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .i_clk(clk), .i_rst(rst), .i_start(h_start), .i_op_sub(h_op_sub), .i_a(h_a), .i_b(h_b),
        .o_busy(h_busy), .o_done(h_done), .o_result(h_result), .o_flags(h_flags)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result got=%h want=00000000", result);
        end
        if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", flags); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < NV; i++) begin
            exp_t e;
            int   cyc;
            @(negedge clk);
            a = va[i]; b = vb[i]; op_sub = vs[i]; start = 1'b1;
            sb.push_back('{res: vr[i], flg: vf[i]});
            @(posedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_vec%0d got=%b want=1", i, busy); end
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (done !== 1'b1 && cyc < 10) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            e = sb.pop_front();
            n_checks += 4;
            if (cyc != 4) begin n_fail++; $display("FAIL latency_vec%0d got=%0d want=4", i, cyc); end
            if (result !== e.res) begin
                n_fail++; $display("FAIL result_vec%0d got=%h want=%h", i, result, e.res);
            end
            if (flags !== e.flg) begin
                n_fail++; $display("FAIL flags_vec%0d got=%b want=%b", i, flags, e.flg);
            end
            @(posedge clk);
            #1;
            if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_vec%0d got=%b want=0", i, done); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; start = 1'b1;
        sb.push_back('{res: 32'h40400000, flg: 4'b0000});
        @(posedge clk);
        #1;
        @(negedge clk);
        // start stays high; these operands must only be taken in the done cycle
        a = 32'hC0000000; b = 32'h3F800000; op_sub = 1'b1;
        sb.push_back('{res: 32'hC0400000, flg: 4'b0000});
        cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        n_checks += 2;
        if (cyc != 4) begin n_fail++; $display("FAIL b2b_latency1 got=%0d want=4", cyc); end
        if (result !== e.res) begin n_fail++; $display("FAIL b2b_result1 got=%h want=%h", result, e.res); end
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                n_checks += 2;
                if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop got=%b want=0", done); end
                if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b want=1", busy); end
            end
        end while (done !== 1'b1 && cyc < 12);
        e = sb.pop_front();
        n_checks += 2;
        if (cyc != 5) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=5", cyc); end
        if (result !== e.res) begin n_fail++; $display("FAIL b2b_result2 got=%h want=%h", result, e.res); end
    endtask

    task automatic test_reset_midop();
        int pulses;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        n_checks += 3;
        if (pulses != 0) begin n_fail++; $display("FAIL midrst_done got=%0d want=0", pulses); end
        if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got=%h want=0", result); end
        if (flags !== 4'h0) begin n_fail++; $display("FAIL midrst_flags got=%b want=0", flags); end
    endtask

    task automatic test_half();
        logic [15:0] ha[2] = '{16'h3C00, 16'h3C00};
        logic [15:0] hb[2] = '{16'h4000, 16'h3C00};
        logic        hs[2] = '{1'b0, 1'b1};
        logic [31:0] hr[2] = '{32'h00004200, 32'h00000000};
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int   cyc;
            @(negedge clk);
            h_a = ha[i]; h_b = hb[i]; h_op_sub = hs[i]; h_start = 1'b1;
            sb.push_back('{res: hr[i], flg: 4'b0000});
            @(posedge clk);
            #1;
            @(negedge clk);
            h_start = 1'b0;
            cyc = 0;
            while (h_done !== 1'b1 && cyc < 10) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            e = sb.pop_front();
            n_checks += 3;
            if (cyc != 4) begin n_fail++; $display("FAIL half_latency%0d got=%0d want=4", i, cyc); end
            if ({16'h0, h_result} !== e.res) begin
                n_fail++; $display("FAIL half_result%0d got=%h want=%h", i, h_result, e.res[15:0]);
            end
            if (h_flags !== e.flg) begin
                n_fail++; $display("FAIL half_flags%0d got=%b want=%b", i, h_flags, e.flg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midop();
        test_half();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Multi-cycle, parametrised IEEE-754-style floating-point adder/subtractor for the FPU datapath. It replaces the single-cycle combinational single-precision adder with a generic exponent/mantissa width and add/subtract modes. It also adds round-to-nearest-even, special-value handling and status flags. The CPU issues an operation with `start` and collects `result` on the one-cycle `done` pulse.

## Interface
- `EXP_W`, default 8: exponent field width, range 4–11.
- `MAN_W`, default 23: stored fraction width, excluding the hidden bit, range 4–52.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request; sampled only while `busy`=0.
- `op_sub`  in  1  0: a+b, 1: a−b (b sign inverted at capture).
- `a`, `b`  in  EXP_W+MAN_W+1 each  operands {sign, exponent, fraction}.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `result`/flags valid.
- `result`  out  EXP_W+MAN_W+1  sum/difference; held until next accepted `start`.
- `flags`  out  4  {invalid, overflow, underflow, inexact}; held with `result`.

## Operation
- Bias = 2^(EXP_W−1)−1. Exponent all-ones means Inf/NaN. Exponent zero means zero; nonzero subnormal inputs are flushed to a zero with the same sign (no flag).
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → IDLE. Exactly one cycle per non-IDLE state.
- IDLE: on `start`, register a, b^(op_sub<<MSB). Go to ALIGN.
- ALIGN:
  - Order operands by magnitude {exp, frac}; the larger is L.
  - Append hidden bit, plus guard/round/sticky (3 bits) below the LSB.
  - Shift the smaller right by the exponent difference; ORed-out bits go into sticky.
  - A difference ≥ MAN_W+3 leaves only sticky.
  - Detect specials here.
- ADD: same effective sign adds; otherwise subtracts smaller from L (never negative). Datapath width MAN_W+5 bits (carry, hidden, fraction, G, R, S).
- NORM:
  - Carry out: shift right 1 (sticky-preserving), exp+1.
  - Otherwise a leading-zero count with one-cycle priority encode; shift left, exp−count.
  - Zero magnitude gives an exact zero.
  - A result exponent ≤0 flushes to zero with sign of L; sets underflow and inexact.
- ROUND:
  - Round to nearest, ties to even: increment if G & (R|S|LSB).
  - Mantissa overflow from rounding renormalises (exp+1).
  - Exponent ≥ all-ones gives ±Inf; sets overflow and inexact.
  - Any nonzero G/R/S sets inexact.
- Special rules, result forced in ALIGN and carried to ROUND unchanged:
  - Any NaN input gives canonical qNaN {0, all-ones, 1000…0}; invalid set only for signaling NaN inputs (fraction MSB=0).
  - Inf + (−Inf) gives qNaN with invalid.
  - Inf ± finite gives that Inf.
- Exact zero sign:
  - +0 for x−x.
  - −0 only when both effective operands are −0.
- Result sign = sign of L.

## Timing
- Reset, asynchronous, any state: FSM=IDLE; `busy`=0, `done`=0, `result`=0, `flags`=0. A reset mid-operation discards the operation, and no `done` follows.
- Accept at edge k (start=1, busy=0). `busy`=1 after edges k..k+3. `done`=1 and `result` updated after edge k+4, so latency is 4 cycles.
- Throughput: one operation per 5 cycles.
- `start` is ignored while `busy`=1.
- `start` in the same cycle as `done`=1 (FSM is in IDLE) is accepted; `done` then drops next cycle.
- `done` is never asserted for two consecutive cycles.
- `result`/`flags` change only on the `done` edge or reset.

## Test plan
- Default params. a=0x3F800000, b=0x40000000, op_sub=0 → after 4 cycles done=1, result=0x40400000, flags=0000.
- a=0x3FC00000, b=0x3FC00000, op_sub=1 → result=0x00000000, flags=0000. Repeat with a=b=0x80000000, op_sub=0 → 0x80000000.
- Rounding:
  - 0x3F800000+0x33800000 (tie) → 0x3F800000, inexact=1.
  - 0x3F800000+0x33800001 → 0x3F800001, inexact=1.
  - 0x3F800001+0x33800000 → 0x3F800002.
- Specials:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, flags=0101.
  - 0x7F800000−0x7F800000 → 0x7FC00000, flags=1000.
  - 0x7F800000+0x3F800000 → 0x7F800000, flags=0000.
- Massive cancellation: 0x3F800001−0x3F800000 → 0x34000000, exact. Back-to-back start held high: second operation accepted in the done cycle, its done exactly 5 cycles after the first.
- Protocol: assert rst two cycles after start → busy=0, done never pulses, result=0. EXP_W=5, MAN_W=10 build: 0x3C00+0x4000 → 0x4200.
